// File: rtl/mdu_sequencer_pkg.sv
// Shared constants and types for the RV32M multiply/divide sequencer.
package mdu_sequencer_pkg;

    localparam int MDU_ITER = 32;
    localparam int CNT_W    = 6;

    // M-extension funct3 encodings
    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } funct3_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_CALC = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_e;

    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_DIV = 1'b1
    } step_mode_e;

    // rs1 is treated as signed for MULH, MULHSU, DIV and REM
    function automatic logic rs1_signed(funct3_e f);
        return f inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
    endfunction

    // rs2 is treated as signed for MULH, DIV and REM
    function automatic logic rs2_signed(funct3_e f);
        return f inside {F3_MULH, F3_DIV, F3_REM};
    endfunction

    // two's-complement negate when neg is set
    function automatic logic [31:0] negate_if(logic [31:0] v, logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mdu_sequencer_if.sv
// Issue/result bundle between the EX stage and the multiply/divide sequencer.
interface mdu_sequencer_if;

    logic        start_in;
    logic [2:0]  funct3_in;
    logic [31:0] rs1_in;
    logic [31:0] rs2_in;
    logic        flush_in;
    logic        busy_out;
    logic        done_out;
    logic [31:0] result_out;

    modport master (
        output start_in, funct3_in, rs1_in, rs2_in, flush_in,
        input  busy_out, done_out, result_out
    );

    modport slave (
        input  start_in, funct3_in, rs1_in, rs2_in, flush_in,
        output busy_out, done_out, result_out
    );

endinterface

// File: rtl/mdu_iter_step.sv
// One iteration of the multiply/divide loop: shift-add (multiply) or
// restoring subtract (divide). The quotient bit is returned separately;
// the caller shifts it into the vacated LSB of the accumulator.
module mdu_iter_step
    import mdu_sequencer_pkg::*;
(
    input  logic [63:0] acc,
    input  logic [31:0] operand,
    input  step_mode_e  mode,
    output logic [63:0] acc_next,
    output logic        q_bit
);

    logic [32:0] add_sum;
    logic [32:0] shifted;
    logic [32:0] diff;

    // single combinational step for either mode
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        acc_next = acc;
        q_bit    = 1'b0;
        add_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, operand} : 33'd0);
        shifted  = {acc[63:32], acc[31]};
        diff     = shifted - {1'b0, operand};
        if (mode == MODE_MUL) begin
            acc_next = {add_sum, acc[31:1]};
        end else begin
            // a set top bit means the shifted remainder already exceeds any divisor
            q_bit    = shifted[32] | ~diff[32];
            acc_next = {(q_bit ? diff[31:0] : shifted[31:0]), acc[30:0], 1'b0};
        end
    end

endmodule

// File: rtl/mdu_sequencer.sv
// Iterative RV32M multiply/divide sequencer: 32-step shift-add or restoring
// divide, sign fix-up, early exit for divide-by-zero and signed overflow.
module mdu_sequencer
    import mdu_sequencer_pkg::*;
#(
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    mdu_sequencer_if.slave bus
);

    state_e           state_q, state_d;
    funct3_e          op_q;
    logic [31:0]      rs1_q, rs2_q, opnd_q, result_q;
    logic [63:0]      acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             neg_q;

    logic             accept, is_div, div_zero, overflow, early;
    logic             sign1, sign2, neg_d;
    logic [31:0]      mag1, mag2, special_result, fix_result, sel, result_d;
    logic [63:0]      prod, step_acc;
    logic             step_q;
    step_mode_e       step_mode;

    mdu_iter_step u_step (
        .acc      (acc_q),
        .operand  (opnd_q),
        .mode     (step_mode),
        .acc_next (step_acc),
        .q_bit    (step_q)
    );

    // operand decode, special-case detection and result selection
    always_comb begin
        is_div    = op_q[2];
        step_mode = is_div ? MODE_DIV : MODE_MUL;
        sign1     = rs1_signed(op_q) & rs1_q[31];
        sign2     = rs2_signed(op_q) & rs2_q[31];
        mag1      = negate_if(rs1_q, sign1);
        mag2      = negate_if(rs2_q, sign2);
        div_zero  = is_div && (rs2_q == 32'd0);
        overflow  = is_div && !op_q[0] && (rs1_q == 32'h8000_0000) && (rs2_q == 32'hFFFF_FFFF);
        early     = EARLY_OUT && (div_zero || overflow);
        // a zero divisor keeps the all-ones quotient positive
        if (is_div) neg_d = op_q[1] ? sign1 : ((sign1 ^ sign2) & ~div_zero);
        else        neg_d = sign1 ^ sign2;
        if (div_zero) special_result = op_q[1] ? rs1_q : 32'hFFFF_FFFF;
        else          special_result = op_q[1] ? 32'd0 : 32'h8000_0000;
        prod = neg_q ? (~acc_q + 64'd1) : acc_q;
        sel  = op_q[1] ? acc_q[63:32] : acc_q[31:0];
        if (is_div)                fix_result = negate_if(sel, neg_q);
        else if (op_q == F3_MUL)   fix_result = prod[31:0];
        else                       fix_result = prod[63:32];
        result_d = (state_q == S_PREP) ? special_result : fix_result;
    end

    // next-state logic and status outputs
    always_comb begin
        state_d      = state_q;
        accept       = (state_q == S_IDLE || state_q == S_DONE) && bus.start_in && !bus.flush_in;
        bus.busy_out = (state_q == S_PREP) || (state_q == S_CALC) || (state_q == S_FIX);
        bus.done_out = (state_q == S_DONE);
        if (bus.flush_in) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (accept) state_d = S_PREP;
                S_PREP:  state_d = early ? S_DONE : S_CALC;
                S_CALC:  if (cnt_q == CNT_W'(MDU_ITER - 1)) state_d = S_FIX;
                S_FIX:   state_d = S_DONE;
                S_DONE:  state_d = accept ? S_PREP : S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // state register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // operand latches, loop datapath and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: operand latches are reset too; PREP decodes them unconditionally.
            op_q     <= F3_MUL;
            rs1_q    <= '0;
            rs2_q    <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            if (accept) begin
                op_q  <= funct3_e'(bus.funct3_in);
                rs1_q <= bus.rs1_in;
                rs2_q <= bus.rs2_in;
            end
            if (state_q == S_PREP) begin
                neg_q  <= neg_d;
                opnd_q <= is_div ? mag2 : mag1;
                acc_q  <= {32'd0, (is_div ? mag1 : mag2)};
                cnt_q  <= '0;
            end
            if (state_q == S_CALC) begin
                acc_q <= step_acc | {63'd0, step_q};
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (state_d == S_DONE) result_q <= result_d;
        end
    end

    assign bus.result_out = result_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: directed vectors, flush/reset/
// back-to-back sequences and random operations against an arithmetic model.
// Two instances (early-out on and off) receive identical stimulus.
module tb_mdu_sequencer;
    import mdu_sequencer_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mdu_sequencer_if bus_e ();
    mdu_sequencer_if bus_n ();

    mdu_sequencer #(.EARLY_OUT(1'b1)) dut   (.clk(clk), .rst(rst), .bus(bus_e));
    mdu_sequencer #(.EARLY_OUT(1'b0)) dut_n (.clk(clk), .rst(rst), .bus(bus_n));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic start, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic flush);
        bus_e.start_in = start; bus_n.start_in = start;
        bus_e.funct3_in = f3;   bus_n.funct3_in = f3;
        bus_e.rs1_in = a;       bus_n.rs1_in = a;
        bus_e.rs2_in = b;       bus_n.rs2_in = b;
        bus_e.flush_in = flush; bus_n.flush_in = flush;
    endtask

    // RV32M semantics computed with wide arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [63:0] sa, sb;
        logic [63:0] ua, ub, p;
        logic [31:0] r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        r  = '0;
        case (f3)
            3'b000: begin p = ua * ub;          r = p[31:0];  end
            3'b001: begin p = sa * sb;          r = p[63:32]; end
            3'b010: begin p = sa * $signed(ub); r = p[63:32]; end
            3'b011: begin p = ua * ub;          r = p[63:32]; end
            3'b100: begin p = sa / sb;          r = (b == 0) ? 32'hFFFF_FFFF : p[31:0]; end
            3'b101: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin p = sa % sb;          r = (b == 0) ? a : p[31:0]; end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        return (f3[2] && b == 0) ||
               ((f3 == 3'b100 || f3 == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] pick();
        logic [31:0] r;
        case ($urandom_range(0, 5))
            0: r = 32'd0;
            1: r = 32'd1;
            2: r = 32'hFFFF_FFFF;
            3: r = 32'h8000_0000;
            4: r = 32'($urandom_range(0, 15));
            default: r = $urandom();
        endcase
        return r;
    endfunction

    // Issue one op at the current cycle and follow it to completion on both
    // instances. Returns in the cycle where the later done pulse is visible.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input bit noise, input string name);
        bit sp;
        int lat_e, lat_n, done_e, done_n;
        bit bad_e, bad_n;
        sp     = is_special(f3, a, b);
        lat_e  = sp ? 2 : 35;
        lat_n  = 35;
        done_e = 0; done_n = 0; bad_e = 0; bad_n = 0;
        drive(1'b1, f3, a, b, 1'b0);
        tick();
        drive(1'b0, 3'($urandom), $urandom(), $urandom(), 1'b0);
        for (int c = 1; c <= 40; c++) begin
            if (done_e == 0 && bus_e.done_out) done_e = c;
            if (done_n == 0 && bus_n.done_out) done_n = c;
            if (c <= lat_e && bus_e.busy_out !== (c < lat_e)) bad_e = 1;
            if (c <= lat_n && bus_n.busy_out !== (c < lat_n)) bad_n = 1;
            if (c > lat_e && (bus_e.done_out || bus_e.busy_out)) bad_e = 1;
            if (done_e != 0 && done_n != 0) break;
            if (noise && !sp && c < 34) begin
                bus_e.start_in = 1'($urandom_range(0, 1));
                bus_n.start_in = bus_e.start_in;
            end else begin
                bus_e.start_in = 1'b0;
                bus_n.start_in = 1'b0;
            end
            tick();
        end
        bus_e.start_in = 1'b0;
        bus_n.start_in = 1'b0;
        check({name, " latency_early"}, 32'(done_e), 32'(lat_e));
        check({name, " latency_full"},  32'(done_n), 32'(lat_n));
        check({name, " busy_early"},    32'(bad_e), 32'd0);
        check({name, " busy_full"},     32'(bad_n), 32'd0);
        check({name, " result_early"},  bus_e.result_out, exp);
        check({name, " result_full"},   bus_n.result_out, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [2:0]  f3;
        logic [31:0] a, b;

        vecs.push_back('{F3_MUL,    32'd7,           32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7_m3"});
        vecs.push_back('{F3_MULHU,  32'hFFFF_FFFF,   32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max"});
        vecs.push_back('{F3_MULH,   32'hFFFF_FFFF,   32'hFFFF_FFFF, 32'h0000_0000, "mulh_m1"});
        vecs.push_back('{F3_MULHSU, 32'hFFFF_FFFF,   32'd2,         32'hFFFF_FFFF, "mulhsu_m1_2"});
        vecs.push_back('{F3_DIV,    32'hFFFF_FFF9,   32'd2,         32'hFFFF_FFFD, "div_m7_2"});
        vecs.push_back('{F3_REM,    32'hFFFF_FFF9,   32'd2,         32'hFFFF_FFFF, "rem_m7_2"});
        vecs.push_back('{F3_DIVU,   32'd100,         32'd7,         32'd14,        "divu_100_7"});
        vecs.push_back('{F3_REMU,   32'd100,         32'd7,         32'd2,         "remu_100_7"});
        vecs.push_back('{F3_DIVU,   32'd5,           32'd0,         32'hFFFF_FFFF, "divu_by0"});
        vecs.push_back('{F3_REM,    32'd5,           32'd0,         32'd5,         "rem_by0"});
        vecs.push_back('{F3_DIV,    32'h8000_0000,   32'hFFFF_FFFF, 32'h8000_0000, "div_ovf"});
        vecs.push_back('{F3_REM,    32'h8000_0000,   32'hFFFF_FFFF, 32'd0,         "rem_ovf"});
        vecs.push_back('{F3_DIV,    32'hFFFF_FFFB,   32'd0,         32'hFFFF_FFFF, "div_neg_by0"});
        vecs.push_back('{F3_REM,    32'hFFFF_FFFB,   32'd0,         32'hFFFF_FFFB, "rem_neg_by0"});
        vecs.push_back('{F3_MULH,   32'h8000_0000,   32'h8000_0000, 32'h4000_0000, "mulh_min_min"});
        vecs.push_back('{F3_MULHSU, 32'h8000_0000,   32'hFFFF_FFFF, 32'h8000_0000, "mulhsu_min_max"});
        vecs.push_back('{F3_REMU,   32'd7,           32'd0,         32'd7,         "remu_by0"});
        vecs.push_back('{F3_DIVU,   32'hFFFF_FFFF,   32'd1,         32'hFFFF_FFFF, "divu_max_1"});

        // reset state
        rst = 1'b1;
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        repeat (3) tick();
        check("reset busy",   32'(bus_e.busy_out), 32'd0);
        check("reset done",   32'(bus_e.done_out), 32'd0);
        check("reset result", bus_e.result_out, 32'd0);
        check("reset result_full", bus_n.result_out, 32'd0);
        rst = 1'b0;
        tick();
        check("idle busy", 32'(bus_e.busy_out | bus_n.busy_out), 32'd0);

        // directed vectors, issued back-to-back from each DONE cycle
        foreach (vecs[i]) run_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0, vecs[i].name);

        // back-to-back: second start held during the DONE cycle of the first
        run_op(F3_MUL, 32'd1234, 32'd5678, 32'd7006652, 1'b0, "b2b_first");
        check("b2b in_done", 32'(bus_e.done_out), 32'd1);
        run_op(F3_DIVU, 32'd100, 32'd7, 32'd14, 1'b1, "b2b_second");

        // flush at cycle 10 of a DIV: result keeps 14, then a restart at cycle 11
        drive(1'b1, F3_DIV, 32'd1000, 32'd3, 1'b0);
        tick();
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        repeat (9) tick();
        bus_e.flush_in = 1'b1; bus_n.flush_in = 1'b1;
        tick();
        bus_e.flush_in = 1'b0; bus_n.flush_in = 1'b0;
        check("flush busy",   32'(bus_e.busy_out | bus_n.busy_out), 32'd0);
        check("flush done",   32'(bus_e.done_out | bus_n.done_out), 32'd0);
        check("flush result", bus_e.result_out, 32'd14);
        check("flush result_full", bus_n.result_out, 32'd14);
        run_op(F3_REM, 32'd1000, 32'd3, 32'd1, 1'b0, "after_flush");

        // flush wins over a same-cycle start
        drive(1'b1, F3_MUL, 32'd3, 32'd3, 1'b1);
        tick();
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        check("flush_prio busy", 32'(bus_e.busy_out | bus_n.busy_out), 32'd0);
        check("flush_prio result", bus_e.result_out, 32'd1);

        // reset mid-CALC
        drive(1'b1, F3_MUL, 32'd12345, 32'd678, 1'b0);
        tick();
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        repeat (14) tick();
        check("midcalc busy", 32'(bus_e.busy_out), 32'd1);
        rst = 1'b1;
        tick();
        check("rst_mid busy",   32'(bus_e.busy_out | bus_n.busy_out), 32'd0);
        check("rst_mid done",   32'(bus_e.done_out | bus_n.done_out), 32'd0);
        check("rst_mid result", bus_e.result_out | bus_n.result_out, 32'd0);
        rst = 1'b0;
        tick();

        // random operations with start noise during busy
        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom());
            a  = pick();
            b  = pick();
            run_op(f3, a, b, ref_model(f3, a, b), 1'b1, $sformatf("rand%0d_f%0d", i, f3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
